// File: rtl/mem_log_reader.sv
// Block-RAM read-out engine: streams words 0..num-1 through a 2-entry skid FIFO.
// Optional MEM_LOG_READER_BASE_ADDR_EN adds i_base_addr for a circular read start.
//
// Ports:
//   clk, i_rst_n (async, active-low)
//   i_start, i_num_words                  dump request, sampled in IDLE
//   i_base_addr (MEM_LOG_READER_BASE_ADDR_EN only)
//   o_read_enable, o_read_addr, i_ram_data  RAM read port, 1-cycle latency
//   o_data, o_valid, i_ready              output stream
//   o_busy, o_done                        status
module mem_log_reader #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_NBIT = 15
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [RAM_ADDR_NBIT:0]   i_num_words,
`ifdef MEM_LOG_READER_BASE_ADDR_EN
  input  logic [RAM_ADDR_NBIT-1:0] i_base_addr,
`endif
  output logic                     o_read_enable,
  output logic [RAM_ADDR_NBIT-1:0] o_read_addr,
  input  logic [RAM_WIDTH-1:0]     i_ram_data,
  output logic [RAM_WIDTH-1:0]     o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int CW = RAM_ADDR_NBIT + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          num_q, num_d;
  logic [CW-1:0]          issued_q, issued_d;
  logic [CW-1:0]          sent_q, sent_d;
  logic                   inflight_q, inflight_d;
  logic [1:0]             count_q, count_d;
  logic [RAM_WIDTH-1:0]   buf0_q, buf0_d;
  logic [RAM_WIDTH-1:0]   buf1_q, buf1_d;
  logic [RAM_ADDR_NBIT-1:0] base_addr;

`ifdef MEM_LOG_READER_BASE_ADDR_EN
  logic [RAM_ADDR_NBIT-1:0] base_q, base_d;
  assign base_addr = base_q;
`else
  assign base_addr = '0;
`endif

  logic       xfer;
  logic       push;
  logic       last;
  logic [2:0] occ;

  assign o_valid = (count_q != 2'd0);
  assign o_data  = buf0_q;
  assign xfer    = o_valid & i_ready;
  assign push    = inflight_q;
  assign last    = xfer && ((sent_q + CW'(1)) == num_q);
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = (state_q == S_DONE);

  // Occupancy after this cycle's pop, counting the read already in flight.
  assign occ = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, xfer};

  assign o_read_enable = (state_q == S_RUN) &&
                         (issued_q < num_q) &&
                         (occ < 3'd2);

  // Address truncates mod depth, so base+issued wraps past the top.
  assign o_read_addr = base_addr + issued_q[RAM_ADDR_NBIT-1:0];

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    inflight_d = o_read_enable;
    count_d    = count_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
`ifdef MEM_LOG_READER_BASE_ADDR_EN
    base_d     = base_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          num_d    = i_num_words;
          issued_d = '0;
          sent_d   = '0;
`ifdef MEM_LOG_READER_BASE_ADDR_EN
          base_d   = i_base_addr;
`endif
          state_d  = (i_num_words == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (o_read_enable) issued_d = issued_q + CW'(1);
        if (xfer)          sent_d   = sent_q + CW'(1);
        if (last)          state_d  = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Shift FIFO: head lives in buf0.
    if (push && xfer) begin
      if (count_q == 2'd1) begin
        buf0_d = i_ram_data;
      end else begin
        buf0_d = buf1_q;
        buf1_d = i_ram_data;
      end
    end else if (xfer) begin
      buf0_d  = buf1_q;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) buf0_d = i_ram_data;
      else                 buf1_d = i_ram_data;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
`ifdef MEM_LOG_READER_BASE_ADDR_EN
      base_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
`ifdef MEM_LOG_READER_BASE_ADDR_EN
      base_q     <= base_d;
`endif
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (i_rst_n) begin
      assert (!(push && !xfer && count_q == 2'd2))
        else $error("mem_log_reader: push into full buffer");
    end
  end
`endif

endmodule

// File: tb/tb_mem_log_reader.sv
// Self-checking bench for mem_log_reader (RAM_ADDR_NBIT=4).
// Scoreboard queues of expected addresses/data, compared on the stream.
module tb_mem_log_reader;

  localparam int N = 4;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N:0]   num_words;
  logic         rd_en;
  logic [N-1:0] rd_addr;
  logic [W-1:0] ram_data;
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         busy;
  logic         done;
`ifdef MEM_LOG_READER_BASE_ADDR_EN
  logic [N-1:0] base_addr;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_data_q[$];
  logic [N-1:0] exp_addr_q[$];

  mem_log_reader #(.RAM_WIDTH(W), .RAM_ADDR_NBIT(N)) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_num_words   (num_words),
`ifdef MEM_LOG_READER_BASE_ADDR_EN
    .i_base_addr   (base_addr),
`endif
    .o_read_enable (rd_en),
    .o_read_addr   (rd_addr),
    .i_ram_data    (ram_data),
    .o_data        (data),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_busy        (busy),
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) ram_data <= 32'hA000 + 32'(rd_addr);
  end

  task automatic run_stream(input int num, input int base,
                            input bit rnd, input bit poke);
    int sent;
    int issued;
    int first_v;
    int eb;
    bit exp_done;
    bit prev_stall;
    bit done_seen;
    bit x;
    logic [W-1:0] prev_data;
    logic [W-1:0] ed;
    logic [N-1:0] ea;
    eb = 0;
`ifdef MEM_LOG_READER_BASE_ADDR_EN
    eb = base;
    base_addr = N'(base);
`endif
    exp_data_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < num; k++) begin
      exp_addr_q.push_back(N'((eb + k) % 16));
      exp_data_q.push_back(32'hA000 + 32'((eb + k) % 16));
    end
    @(negedge clk);
    start = 1'b1;
    num_words = (N+1)'(num);
    ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy num=%0d got=%b want=0", num, busy);
    end
    exp_done = (num == 0);
    prev_stall = 1'b0;
    prev_data = '0;
    first_v = -1;
    sent = 0;
    issued = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      @(negedge clk);
      start = poke && (cyc == 1);
      num_words = (poke && cyc == 1) ? 5'd5 : (N+1)'(num);
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      x = valid && ready;
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done num=%0d cyc=%0d got=%b want=%b",
                 num, cyc, done, exp_done);
      end
      if (done) done_seen = 1'b1;
      if (prev_stall) begin
        checks++;
        if (valid !== 1'b1 || data !== prev_data) begin
          errors++;
          $display("FAIL hold cyc=%0d got=%b/%h want=1/%h",
                   cyc, valid, data, prev_data);
        end
      end
      if (rd_en) begin
        issued++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL extra_read num=%0d addr got=%0d want=none",
                   num, rd_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (rd_addr !== ea) begin
            errors++;
            $display("FAIL addr got=%0d want=%0d", rd_addr, ea);
          end
        end
        checks++;
        if (issued - sent - int'(x) > 2) begin
          errors++;
          $display("FAIL ahead got=%0d want<=2", issued - sent - int'(x));
        end
      end
      if (valid && first_v < 0) begin
        first_v = cyc;
        checks++;
        if (cyc != 2) begin
          errors++;
          $display("FAIL first_valid got=%0d want=2", cyc);
        end
      end
      if (!rnd && sent > 0 && sent < num) begin
        checks++;
        if (valid !== 1'b1) begin
          errors++;
          $display("FAIL bubble cyc=%0d got=%b want=1", cyc, valid);
        end
      end
      exp_done = 1'b0;
      if (x) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word got=%h want=none", data);
        end else begin
          ed = exp_data_q.pop_front();
          if (data !== ed) begin
            errors++;
            $display("FAIL data got=%h want=%h", data, ed);
          end
        end
        sent++;
        if (sent == num) exp_done = 1'b1;
      end
      prev_stall = valid && !ready;
      prev_data = data;
    end
    start = 1'b0;
    ready = 1'b1;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL timeout num=%0d got=no_done want=done", num);
    end
    checks++;
    if (sent != num || exp_data_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL count got=%0d want=%0d", sent, num);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL after_done got=%b want=000", {busy, valid, done});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    num_words = '0;
    ready = 1'b1;
`ifdef MEM_LOG_READER_BASE_ADDR_EN
    base_addr = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_en, rd_addr, data, valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outs got=%b/%0d/%h/%b/%b/%b want=0",
               rd_en, rd_addr, data, valid, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_stream(5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_stream(4, 0, 1'b1, 1'b0);
    run_stream(16, 0, 1'b1, 1'b0);
  endtask

  task automatic test_zero();
    run_stream(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_full_depth();
    run_stream(16, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_dump();
    int nx;
    bit hit;
    @(negedge clk);
    start = 1'b1;
    num_words = 5'd8;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nx = 0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      #1;
      if (valid && ready) nx++;
      if (nx == 2) hit = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_xfers got=%0d want=2", nx);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en, rd_addr, data, valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b/%0d/%h/%b/%b/%b want=0",
               rd_en, rd_addr, data, valid, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({busy, done, valid} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset got=%b want=000", {busy, done, valid});
      end
    end
    run_stream(2, 0, 1'b0, 1'b1);
  endtask

  task automatic test_base_addr();
    run_stream(4, 14, 1'b0, 1'b0);
    run_stream(4, 14, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_full_depth();
    test_reset_mid_dump();
`ifdef MEM_LOG_READER_BASE_ADDR_EN
    test_base_addr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
